// File: rtl/alu_pkg.sv
// Shared types for the RV32 ALU/MDU execute block: pipeline alu_op codes,
// the decoded control enum and the sequencer state encoding.
package alu_pkg;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
   localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

   // Base codes keep the legacy 4-bit values; bit 4 marks the M-extension.
   typedef enum logic [4:0] {
      ALU_AND    = 5'b00000,
      ALU_OR     = 5'b00001,
      ALU_ADD    = 5'b00010,
      ALU_SLL    = 5'b00011,
      ALU_SLT    = 5'b00100,
      ALU_SLTU   = 5'b00101,
      ALU_SUB    = 5'b00110,
      ALU_XOR    = 5'b00111,
      ALU_SRL    = 5'b01000,
      ALU_SRA    = 5'b01010,
      ALU_MUL    = 5'b10000,
      ALU_MULH   = 5'b10001,
      ALU_MULHSU = 5'b10010,
      ALU_MULHU  = 5'b10011,
      ALU_DIV    = 5'b10100,
      ALU_DIVU   = 5'b10101,
      ALU_REM    = 5'b10110,
      ALU_REMU   = 5'b10111
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide engine: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one step per cycle, sign fix-up on the last step.
module mdu_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic            iter_i,
   input  logic            flush_i,
   input  logic            is_div_i,
   input  logic            sel_hi_i,
   input  logic            a_signed_i,
   input  logic            b_signed_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);
   localparam int CW = $clog2(XLEN);

   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, mb_q, mb_d;
   logic              negq_q, negq_d, negr_q, negr_d, div_q, div_d, selhi_q, selhi_d;

   logic              a_neg, b_neg, q_bit;
   logic [XLEN-1:0]   mag_a, mag_b, r_nxt, q_nxt;
   logic [XLEN:0]     sum, shifted;
   logic [2*XLEN-1:0] prod, prod_fix;

   always_comb begin
      a_neg    = a_signed_i & op_a_i[XLEN-1];
      b_neg    = b_signed_i & op_b_i[XLEN-1];
      mag_a    = a_neg ? -op_a_i : op_a_i;
      mag_b    = b_neg ? -op_b_i : op_b_i;
      // hi:lo is the product accumulator for mul, remainder:quotient for div
      sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mb_q} : '0);
      prod     = {sum, lo_q[XLEN-1:1]};
      prod_fix = negq_q ? -prod : prod;
      shifted  = {hi_q, lo_q[XLEN-1]};
      q_bit    = (shifted >= {1'b0, mb_q});
      r_nxt    = q_bit ? XLEN'(shifted - {1'b0, mb_q}) : shifted[XLEN-1:0];
      q_nxt    = {lo_q[XLEN-2:0], q_bit};
      done_o   = iter_i && (cnt_q == CW'(XLEN-1));

      if (div_q)
         result_o = selhi_q ? (negr_q ? -r_nxt : r_nxt) : (negq_q ? -q_nxt : q_nxt);
      else
         result_o = selhi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];

      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      mb_d    = mb_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      div_d   = div_q;
      selhi_d = selhi_q;

      if (start_i) begin
         cnt_d   = '0;
         hi_d    = '0;
         lo_d    = is_div_i ? mag_a : mag_b;
         mb_d    = is_div_i ? mag_b : mag_a;
         negq_d  = a_neg ^ b_neg;
         negr_d  = a_neg;
         div_d   = is_div_i;
         selhi_d = sel_hi_i;
      end else if (iter_i) begin
         cnt_d = done_o ? '0 : cnt_q + CW'(1);
         if (div_q) begin
            hi_d = r_nxt;
            lo_d = q_nxt;
         end else begin
            hi_d = prod[2*XLEN-1:XLEN];
            lo_d = prod[XLEN-1:0];
         end
      end
      if (flush_i)
         cnt_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         mb_q    <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         div_q   <= 1'b0;
         selhi_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         mb_q    <= mb_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         div_q   <= div_d;
         selhi_q <= selhi_d;
      end
   end

endmodule

// File: rtl/alu_mdu_seq.sv
// RV32 EX-stage ALU control and execute: decode, single-cycle base ALU,
// divide fast paths and the sequencer around the iterative mul/div engine.
module alu_mdu_seq
   import alu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter bit EN_M = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      alu_op,
   input  logic            func7_5,
   input  logic            func7_0,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            out_valid,
   output logic [XLEN-1:0] result,
   output logic            illegal,
   output logic            busy
);
   localparam int SHW = $clog2(XLEN);

   state_e          state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            illegal_q, illegal_d;

   alu_ctrl_e       ctrl;
   logic            dec_ill, mul_cls, div_cls, b_zero, ovf, fast_hit;
   logic            sel_hi, a_signed, b_signed, mdu_start, mdu_iter_en, mdu_done;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] alu_res, fast_res, mdu_res;

   always_comb begin
      ctrl    = ALU_ADD;
      dec_ill = 1'b0;
      case (alu_op)
         ALU_OP_ADD: ctrl = ALU_ADD;
         ALU_OP_SUB: ctrl = ALU_SUB;
         ALU_OP_RTYPE: begin
            if (func7_0) begin
               if (!EN_M || func7_5) dec_ill = 1'b1;
               else                  ctrl = alu_ctrl_e'({2'b10, func3});
            end else begin
               case ({func7_5, func3})
                  4'b0000: ctrl = ALU_ADD;
                  4'b1000: ctrl = ALU_SUB;
                  4'b0111: ctrl = ALU_AND;
                  4'b0110: ctrl = ALU_OR;
                  4'b0001: ctrl = ALU_SLL;
                  4'b0010: ctrl = ALU_SLT;
                  4'b0011: ctrl = ALU_SLTU;
                  4'b0100: ctrl = ALU_XOR;
                  4'b0101: ctrl = ALU_SRL;
                  4'b1101: ctrl = ALU_SRA;
                  default: dec_ill = 1'b1;
               endcase
            end
         end
         default: begin
            // func7_5 of an I-type is immediate bit 10 except on shifts
            case (func3)
               3'b000:  ctrl = ALU_ADD;
               3'b010:  ctrl = ALU_SLT;
               3'b011:  ctrl = ALU_SLTU;
               3'b100:  ctrl = ALU_XOR;
               3'b110:  ctrl = ALU_OR;
               3'b111:  ctrl = ALU_AND;
               3'b001: begin
                  if (func7_5) dec_ill = 1'b1;
                  else         ctrl = ALU_SLL;
               end
               default: ctrl = func7_5 ? ALU_SRA : ALU_SRL;
            endcase
         end
      endcase

      mul_cls  = !dec_ill && (ctrl inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU});
      div_cls  = !dec_ill && (ctrl inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU});
      sel_hi   = mul_cls ? (ctrl != ALU_MUL) : (ctrl inside {ALU_REM, ALU_REMU});
      a_signed = ctrl inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
      b_signed = ctrl inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
   end

   always_comb begin
      shamt = op_b[SHW-1:0];
      case (ctrl)
         ALU_ADD:  alu_res = op_a + op_b;
         ALU_SUB:  alu_res = op_a - op_b;
         ALU_AND:  alu_res = op_a & op_b;
         ALU_OR:   alu_res = op_a | op_b;
         ALU_XOR:  alu_res = op_a ^ op_b;
         ALU_SLL:  alu_res = op_a << shamt;
         ALU_SRL:  alu_res = op_a >> shamt;
         ALU_SRA:  alu_res = $signed(op_a) >>> shamt;
         ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
         default:  alu_res = '0;
      endcase

      b_zero   = (op_b == '0);
      ovf      = (ctrl inside {ALU_DIV, ALU_REM}) && (op_a == {1'b1, {(XLEN-1){1'b0}}})
                 && (op_b == '1);
      fast_hit = b_zero || ovf;
      fast_res = '0;
      if (b_zero)
         fast_res = (ctrl inside {ALU_DIV, ALU_DIVU}) ? '1 : op_a;
      else if (ovf && ctrl == ALU_DIV)
         fast_res = op_a;
   end

   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      illegal_d   = illegal_q;
      mdu_start   = 1'b0;
      mdu_iter_en = (state_q == ST_MUL || state_q == ST_DIV) && !flush;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && !flush) begin
               if (dec_ill) begin
                  state_d   = ST_DONE;
                  result_d  = '0;
                  illegal_d = 1'b1;
               end else if (mul_cls) begin
                  state_d   = ST_MUL;
                  mdu_start = 1'b1;
               end else if (div_cls && !fast_hit) begin
                  state_d   = ST_DIV;
                  mdu_start = 1'b1;
               end else begin
                  state_d   = ST_DONE;
                  result_d  = div_cls ? fast_res : alu_res;
                  illegal_d = 1'b0;
               end
            end
         end
         ST_MUL, ST_DIV: begin
            if (mdu_done) begin
               state_d   = ST_DONE;
               result_d  = mdu_res;
               illegal_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (flush)
         state_d = ST_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         result_q  <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         illegal_q <= illegal_d;
      end
   end

   mdu_iter #(.XLEN(XLEN)) u_mdu_iter (
      .clk        (clk),
      .rst        (rst),
      .start_i    (mdu_start),
      .iter_i     (mdu_iter_en),
      .flush_i    (flush),
      .is_div_i   (div_cls),
      .sel_hi_i   (sel_hi),
      .a_signed_i (a_signed),
      .b_signed_i (b_signed),
      .op_a_i     (op_a),
      .op_b_i     (op_b),
      .done_o     (mdu_done),
      .result_o   (mdu_res)
   );

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE) && !flush;
   assign busy      = (state_q == ST_MUL) || (state_q == ST_DIV);
   assign result    = result_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed bench for alu_mdu_seq: base ops, M ops, fast paths, flush and reset.
module tb_alu_mdu_seq;
   logic        clk, rst, in_valid, in_ready, func7_5, func7_0, flush;
   logic        out_valid, illegal, busy;
   logic [1:0]  alu_op;
   logic [2:0]  func3;
   logic [31:0] op_a, op_b, result;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      string       nm;
      logic [1:0]  aop;
      logic        f75;
      logic        f70;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      logic        ill;
      int          lat;
   } vec_t;

   vec_t base_q[$];
   vec_t mdu_q[$];

   alu_mdu_seq #(.XLEN(32), .EN_M(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .func7_5   (func7_5),
      .func7_0   (func7_0),
      .func3     (func3),
      .op_a      (op_a),
      .op_b      (op_b),
      .flush     (flush),
      .out_valid (out_valid),
      .result    (result),
      .illegal   (illegal),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   // Issue one op; lat counts negedges after the accepting posedge (0 = timed out).
   task automatic run_op(input logic [1:0] aop, input logic f75, input logic f70,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic ill, output int lat,
                         output int nbusy);
      res = '0; ill = 1'b0; lat = 0; nbusy = 0;
      @(negedge clk);
      in_valid = 1'b1; alu_op = aop; func7_5 = f75; func7_0 = f70; func3 = f3;
      op_a = a; op_b = b;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (busy) nbusy++;
         if (out_valid) begin
            lat = c; res = result; ill = illegal;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid got %b want 0", out_valid); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready got %b want 1", in_ready); end
      n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL reset result got %h want 0", result); end
      n_vec++; if (illegal !== 1'b0) begin n_err++; $display("FAIL reset illegal got %b want 0", illegal); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy got %b want 0", busy); end
      rst = 1'b0;
   endtask

   task automatic test_base_ops();
      logic [31:0] r; logic il; int lat, nb;
      base_q.push_back('{"addi_neg", 2'b11, 1'b1, 1'b0, 3'b000, 32'd10, 32'hFFFF_FFFD, 32'd7, 1'b0, 1});
      base_q.push_back('{"sra", 2'b10, 1'b1, 1'b0, 3'b101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1});
      base_q.push_back('{"sll_f75_ill", 2'b10, 1'b1, 1'b0, 3'b001, 32'h8000_0000, 32'd4, 32'h0, 1'b1, 1});
      base_q.push_back('{"ld_add", 2'b00, 1'b0, 1'b0, 3'b000, 32'd5, 32'd6, 32'd11, 1'b0, 1});
      base_q.push_back('{"br_sub", 2'b01, 1'b0, 1'b0, 3'b000, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1});
      base_q.push_back('{"r_sub", 2'b10, 1'b1, 1'b0, 3'b000, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1});
      base_q.push_back('{"slt", 2'b10, 1'b0, 1'b0, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1});
      base_q.push_back('{"sltu", 2'b10, 1'b0, 1'b0, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1});
      base_q.push_back('{"and", 2'b10, 1'b0, 1'b0, 3'b111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1});
      base_q.push_back('{"or", 2'b10, 1'b0, 1'b0, 3'b110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1});
      base_q.push_back('{"xor", 2'b10, 1'b0, 1'b0, 3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0, 1});
      base_q.push_back('{"srl", 2'b10, 1'b0, 1'b0, 3'b101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1});
      base_q.push_back('{"sll_shamt_mask", 2'b10, 1'b0, 1'b0, 3'b001, 32'd1, 32'h23, 32'd8, 1'b0, 1});
      base_q.push_back('{"r_key_ill", 2'b10, 1'b1, 1'b0, 3'b111, 32'd1, 32'd2, 32'h0, 1'b1, 1});
      base_q.push_back('{"m_f75_ill", 2'b10, 1'b1, 1'b1, 3'b000, 32'd3, 32'd4, 32'h0, 1'b1, 1});
      base_q.push_back('{"srai", 2'b11, 1'b1, 1'b0, 3'b101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1});
      base_q.push_back('{"srli", 2'b11, 1'b0, 1'b0, 3'b101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1});
      base_q.push_back('{"slli_31", 2'b11, 1'b0, 1'b0, 3'b001, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1});
      base_q.push_back('{"slti_neg", 2'b11, 1'b1, 1'b0, 3'b010, 32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'd1, 1'b0, 1});
      base_q.push_back('{"slli_f75_ill", 2'b11, 1'b1, 1'b0, 3'b001, 32'd1, 32'd1, 32'h0, 1'b1, 1});
      foreach (base_q[i]) begin
         run_op(base_q[i].aop, base_q[i].f75, base_q[i].f70, base_q[i].f3, base_q[i].a, base_q[i].b, r, il, lat, nb);
         n_vec++; if (r !== base_q[i].exp) begin n_err++; $display("FAIL %s result got %h want %h", base_q[i].nm, r, base_q[i].exp); end
         n_vec++; if (il !== base_q[i].ill) begin n_err++; $display("FAIL %s illegal got %b want %b", base_q[i].nm, il, base_q[i].ill); end
         n_vec++; if (lat != base_q[i].lat) begin n_err++; $display("FAIL %s latency got %0d want %0d", base_q[i].nm, lat, base_q[i].lat); end
      end
   endtask

   task automatic test_mdu_ops();
      logic [31:0] r; logic il; int lat, nb;
      mdu_q.push_back('{"mulh", 2'b10, 1'b0, 1'b1, 3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 33});
      mdu_q.push_back('{"mul", 2'b10, 1'b0, 1'b1, 3'b000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 1'b0, 33});
      mdu_q.push_back('{"mul_big", 2'b10, 1'b0, 1'b1, 3'b000, 32'd12345, 32'd1000, 32'd12345000, 1'b0, 33});
      mdu_q.push_back('{"mulhu", 2'b10, 1'b0, 1'b1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33});
      mdu_q.push_back('{"mulhsu", 2'b10, 1'b0, 1'b1, 3'b010, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33});
      mdu_q.push_back('{"div", 2'b10, 1'b0, 1'b1, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33});
      mdu_q.push_back('{"rem", 2'b10, 1'b0, 1'b1, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33});
      mdu_q.push_back('{"div_negb", 2'b10, 1'b0, 1'b1, 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33});
      mdu_q.push_back('{"rem_negb", 2'b10, 1'b0, 1'b1, 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 33});
      mdu_q.push_back('{"divu", 2'b10, 1'b0, 1'b1, 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 33});
      mdu_q.push_back('{"remu", 2'b10, 1'b0, 1'b1, 3'b111, 32'd100, 32'd7, 32'd2, 1'b0, 33});
      mdu_q.push_back('{"divu_minneg", 2'b10, 1'b0, 1'b1, 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 33});
      mdu_q.push_back('{"divu_by0", 2'b10, 1'b0, 1'b1, 3'b101, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1'b0, 1});
      mdu_q.push_back('{"remu_by0", 2'b10, 1'b0, 1'b1, 3'b111, 32'd1234, 32'd0, 32'd1234, 1'b0, 1});
      mdu_q.push_back('{"div_by0", 2'b10, 1'b0, 1'b1, 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1});
      mdu_q.push_back('{"rem_by0", 2'b10, 1'b0, 1'b1, 3'b110, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 1'b0, 1});
      mdu_q.push_back('{"div_ovf", 2'b10, 1'b0, 1'b1, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1});
      mdu_q.push_back('{"rem_ovf", 2'b10, 1'b0, 1'b1, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1});
      foreach (mdu_q[i]) begin
         run_op(mdu_q[i].aop, mdu_q[i].f75, mdu_q[i].f70, mdu_q[i].f3, mdu_q[i].a, mdu_q[i].b, r, il, lat, nb);
         n_vec++; if (r !== mdu_q[i].exp) begin n_err++; $display("FAIL %s result got %h want %h", mdu_q[i].nm, r, mdu_q[i].exp); end
         n_vec++; if (il !== mdu_q[i].ill) begin n_err++; $display("FAIL %s illegal got %b want %b", mdu_q[i].nm, il, mdu_q[i].ill); end
         n_vec++; if (lat != mdu_q[i].lat) begin n_err++; $display("FAIL %s latency got %0d want %0d", mdu_q[i].nm, lat, mdu_q[i].lat); end
         n_vec++; if (nb != mdu_q[i].lat - 1) begin n_err++; $display("FAIL %s busy cycles got %0d want %0d", mdu_q[i].nm, nb, mdu_q[i].lat - 1); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r; logic il; int lat, nb;
      run_op(2'b00, 1'b0, 1'b0, 3'b000, 32'd20, 32'd22, r, il, lat, nb);
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b strobe width out_valid got %b want 0", out_valid); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b in_ready got %b want 1", in_ready); end
      n_vec++; if (result !== 32'd42) begin n_err++; $display("FAIL b2b result hold got %h want %h", result, 32'd42); end
      run_op(2'b01, 1'b0, 1'b0, 3'b000, 32'd22, 32'd20, r, il, lat, nb);
      n_vec++; if (r !== 32'd2 || lat != 1) begin n_err++; $display("FAIL b2b second got %h lat %0d want 2 lat 1", r, lat); end
   endtask

   task automatic test_flush();
      logic [31:0] r; logic il; int lat, nb; logic seen;
      seen = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; alu_op = 2'b10; func7_5 = 1'b0; func7_0 = 1'b1; func3 = 3'b101;
      op_a = 32'd100; op_b = 32'd7;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_mid in_ready got %b want 1", in_ready); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_mid busy got %b want 0", busy); end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_mid stray out_valid got %b want 0", seen); end
      run_op(2'b10, 1'b0, 1'b0, 3'b000, 32'd5, 32'd6, r, il, lat, nb);
      n_vec++; if (r !== 32'd11 || lat != 1) begin n_err++; $display("FAIL flush_then_add got %h lat %0d want 11 lat 1", r, lat); end

      // flush landing in DONE must gate the strobe combinationally
      @(negedge clk);
      in_valid = 1'b1; alu_op = 2'b00; op_a = 32'd1; op_b = 32'd1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL flush_done pre out_valid got %b want 1", out_valid); end
      flush = 1'b1;
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_done gated out_valid got %b want 0", out_valid); end
      @(negedge clk);
      flush = 1'b0;
      n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL flush_done after got rdy %b ov %b want 1 0", in_ready, out_valid); end

      // flush and in_valid together: no accept
      seen = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; flush = 1'b1; alu_op = 2'b00; op_a = 32'd1; op_b = 32'd2;
      @(posedge clk);
      #1 begin in_valid = 1'b0; flush = 1'b0; end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (out_valid || !in_ready) seen = 1'b1;
      end
      n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_wins accept seen got %b want 0", seen); end
   endtask

   task automatic test_rst_mid();
      logic [31:0] r; logic il; int lat, nb; logic seen;
      seen = 1'b0;
      run_op(2'b00, 1'b0, 1'b0, 3'b000, 32'd5, 32'd6, r, il, lat, nb);
      @(negedge clk);
      in_valid = 1'b1; alu_op = 2'b10; func7_5 = 1'b0; func7_0 = 1'b1; func3 = 3'b000;
      op_a = 32'd9; op_b = 32'd9;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int c = 1; c <= 4; c++) @(negedge clk);
      @(negedge clk);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_mid pre busy got %b want 1", busy); end
      rst = 1'b1;
      #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid busy got %b want 0", busy); end
      n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL rst_mid result got %h want 0", result); end
      n_vec++; if (out_valid !== 1'b0 || illegal !== 1'b0) begin n_err++; $display("FAIL rst_mid ov/ill got %b %b want 0 0", out_valid, illegal); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid in_ready got %b want 1", in_ready); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (out_valid || !in_ready) seen = 1'b1;
      end
      n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rst_mid stale activity got %b want 0", seen); end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; alu_op = 2'b00;
      func7_5 = 1'b0; func7_0 = 1'b0; func3 = 3'b000; op_a = '0; op_b = '0;
      test_reset();
      test_base_ops();
      test_mdu_ops();
      test_back_to_back();
      test_flush();
      test_rst_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
